pl_io_responder: RTL and testbench

Memory-mapped I/O responder for the pipelined CPU's data bus. It answers load/store requests in the I/O half of the address space (addr[7] = 1) with a req/ack handshake and optional wait states. It holds four write-back-readable output registers, four synchronized input registers, and a change-flag status register that is cleared on read. It is the target side of the CPU's I/O store/load path and drives board LEDs/displays and samples switches/keys.

---
 rtl/pl_io_responder.sv | 215 +++++++++++++++++++++
 tb/tb_pl_io_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_io_responder.sv
// pl_io_responder
// Memory-mapped I/O target for the CPU data bus. Answers requests whose
// addr[7] is set, using a req/ack handshake with WAIT_CYCLES wait states.
//
// Word map (w = addr[6:2]):
//   0..3  otp0..otp3, read/write
//   4..7  synchronized inp0..inp3, read-only
//   8     change flags in bits[3:0], cleared by a read (a new change wins)
//   9     irq mask in bits[3:0] (only when PL_IO_CHANGE_IRQ_EN is defined)
//   other reads return 0, writes are dropped
//
// Ports:
//   clock, resetn         system clock, async active-low reset
//   req, we, addr, datain request from the initiator, held until ack
//   dataout, ack          load data and one-cycle completion pulse
//   inp0..inp3            asynchronous external inputs
//   otp0..otp3            registered output ports
//   irq                   change interrupt
//
// Build option: PL_IO_CHANGE_IRQ_EN enables the mask register and irq.
// Without it, irq is tied low and word 9 reads 0.
//
// state  | meaning
// S_IDLE | waiting for a request in the I/O half of the address space
// S_WAIT | counting down wait states
// S_ACK  | ack cycle: perform write, or drive dataout and clear flags
module pl_io_responder #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        ack,
  input  logic [31:0] inp0,
  input  logic [31:0] inp1,
  input  logic [31:0] inp2,
  input  logic [31:0] inp3,
  output logic [31:0] otp0,
  output logic [31:0] otp1,
  output logic [31:0] otp2,
  output logic [31:0] otp3,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [4:0]  r_widx;
  logic [31:0] r_wdata;

  logic [31:0] r_otp   [4];
  logic [31:0] r_sync1 [4];
  logic [31:0] r_sync2 [4];
  logic [31:0] r_prev  [4];
  logic [31:0] w_inp   [4];
  logic [3:0]  r_flags;
  logic [3:0]  w_flag_set;
  logic [3:0]  w_flags_nxt;
  logic [3:0]  w_mask_rd;

  logic        w_accept;
  logic        w_ack_cyc;
  logic        w_do_wr;
  logic        w_do_rd;
  logic        w_clr;
  logic [31:0] w_rdata;

  // Only addr[7] and addr[6:2] take part in decode.
  logic        w_unused_addr;
  assign w_unused_addr = ^{addr[31:8], addr[1:0]};

  assign w_inp[0] = inp0;
  assign w_inp[1] = inp1;
  assign w_inp[2] = inp2;
  assign w_inp[3] = inp3;

  assign otp0 = r_otp[0];
  assign otp1 = r_otp[1];
  assign otp2 = r_otp[2];
  assign otp3 = r_otp[3];

  assign w_accept = (r_state == S_IDLE) && req && addr[7];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = (LP_WAIT != 4'd0) ? S_WAIT : S_ACK;
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) w_state_nxt = S_ACK;
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_ack_cyc = (r_state == S_ACK);
    ack       = w_ack_cyc;
    dataout   = (w_ack_cyc && !r_we) ? w_rdata : 32'd0;
  end

  assign w_do_wr = w_ack_cyc && r_we;
  assign w_do_rd = w_ack_cyc && !r_we;
  assign w_clr   = w_do_rd && (r_widx == 5'd8);

  // Request latch and wait-state down-counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_widx  <= 5'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_cnt   <= LP_WAIT;
      r_we    <= we;
      r_widx  <= addr[6:2];
      r_wdata <= datain;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 4; n++) r_otp[n] <= 32'd0;
    end else if (w_do_wr && (r_widx < 5'd4)) begin
      r_otp[r_widx[1:0]] <= r_wdata;
    end
  end

  // Two-flop synchronizer followed by a previous-value copy for change detect.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 4; n++) begin
        r_sync1[n] <= 32'd0;
        r_sync2[n] <= 32'd0;
        r_prev[n]  <= 32'd0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        r_sync1[n] <= w_inp[n];
        r_sync2[n] <= r_sync1[n];
        r_prev[n]  <= r_sync2[n];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) w_flag_set[n] = (r_sync2[n] != r_prev[n]);
  end

  // A change detected in the clearing cycle survives the clear.
  assign w_flags_nxt = (w_clr ? 4'd0 : r_flags) | w_flag_set;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_flags <= 4'd0;
    else         r_flags <= w_flags_nxt;
  end

`ifdef PL_IO_CHANGE_IRQ_EN
  logic [3:0] r_mask;
  logic [3:0] w_mask_nxt;
  logic       r_irq;

  assign w_mask_nxt = (w_do_wr && (r_widx == 5'd9)) ? r_wdata[3:0] : r_mask;

  // Registered from next-state values so irq tracks flags & mask exactly,
  // dropping in the cycle right after a clearing read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mask <= 4'd0;
      r_irq  <= 1'b0;
    end else begin
      r_mask <= w_mask_nxt;
      r_irq  <= |(w_flags_nxt & w_mask_nxt);
    end
  end

  assign w_mask_rd = r_mask;
  assign irq       = r_irq;
`else
  assign w_mask_rd = 4'd0;
  assign irq       = 1'b0;
`endif

  // Read mux on the latched word index.
  always_comb begin
    w_rdata = 32'd0;
    if (r_widx < 5'd4)       w_rdata = r_otp[r_widx[1:0]];
    else if (r_widx < 5'd8)  w_rdata = r_sync2[r_widx[1:0]];
    else if (r_widx == 5'd8) w_rdata = {28'd0, r_flags};
    else if (r_widx == 5'd9) w_rdata = {28'd0, w_mask_rd};
  end

endmodule

// File: tb/tb_pl_io_responder.sv
module tb_pl_io_responder;

`ifdef PL_IO_CHANGE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic        req    [2];
  logic        we     [2];
  logic [31:0] addr   [2];
  logic [31:0] datain [2];
  logic [31:0] inp    [2][4];

  logic [31:0] dout_0, dout_1;
  logic        ack_0, ack_1, irq_0, irq_1;
  logic [31:0] otp_0 [4];
  logic [31:0] otp_1 [4];

  logic [31:0] dout_v [2];
  logic        ack_v  [2];
  logic        irq_v  [2];
  logic [31:0] otp_v  [2][4];

  int n_chk = 0;
  int n_err = 0;

  pl_io_responder #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .resetn(resetn), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .datain(datain[0]), .dataout(dout_0), .ack(ack_0),
    .inp0(inp[0][0]), .inp1(inp[0][1]), .inp2(inp[0][2]), .inp3(inp[0][3]),
    .otp0(otp_0[0]), .otp1(otp_0[1]), .otp2(otp_0[2]), .otp3(otp_0[3]),
    .irq(irq_0)
  );

  pl_io_responder #(.WAIT_CYCLES(3)) dut1 (
    .clock(clock), .resetn(resetn), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .datain(datain[1]), .dataout(dout_1), .ack(ack_1),
    .inp0(inp[1][0]), .inp1(inp[1][1]), .inp2(inp[1][2]), .inp3(inp[1][3]),
    .otp0(otp_1[0]), .otp1(otp_1[1]), .otp2(otp_1[2]), .otp3(otp_1[3]),
    .irq(irq_1)
  );

  always_comb begin
    dout_v[0] = dout_0;  dout_v[1] = dout_1;
    ack_v[0]  = ack_0;   ack_v[1]  = ack_1;
    irq_v[0]  = irq_0;   irq_v[1]  = irq_1;
    for (int n = 0; n < 4; n++) begin
      otp_v[0][n] = otp_0[n];
      otp_v[1][n] = otp_1[n];
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t got=%h exp=%h", nm, i, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  int          cyc = 0;
  logic [31:0] m_otp   [2][4];
  logic [3:0]  m_flags [2];
  logic [3:0]  m_mask  [2];
  logic        m_irq   [2];
  // h1/h2/h3: input values sampled 1/2/3 edges ago
  logic [31:0] h1 [2][4];
  logic [31:0] h2 [2][4];
  logic [31:0] h3 [2][4];
  logic        m_busy  [2];
  int          m_ack_at[2];
  logic        m_we    [2];
  logic [4:0]  m_idx   [2];
  logic [31:0] m_data  [2];

  function automatic logic [31:0] m_read(input int i);
    logic [4:0] x;
    x = m_idx[i];
    if (x < 5'd4)  return m_otp[i][x[1:0]];
    if (x < 5'd8)  return h2[i][x[1:0]];
    if (x == 5'd8) return {28'd0, m_flags[i]};
    if (x == 5'd9) return IRQ_EN ? {28'd0, m_mask[i]} : 32'd0;
    return 32'd0;
  endfunction

  always @(posedge clock or negedge resetn) begin : model
    logic [3:0] set;
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        m_flags[i] = 4'd0; m_mask[i] = 4'd0; m_irq[i] = 1'b0; m_busy[i] = 1'b0;
        m_ack_at[i] = -1; m_we[i] = 1'b0; m_idx[i] = 5'd0; m_data[i] = 32'd0;
        for (int n = 0; n < 4; n++) begin
          m_otp[i][n] = 32'd0; h1[i][n] = 32'd0; h2[i][n] = 32'd0; h3[i][n] = 32'd0;
        end
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        // a change that reached the second sync stage one edge ago is flagged now
        for (int n = 0; n < 4; n++) set[n] = (h2[i][n] != h3[i][n]);
        if (m_busy[i] && (m_ack_at[i] == cyc - 1)) begin
          m_busy[i] = 1'b0;
          if (m_we[i]) begin
            if (m_idx[i] < 5'd4) m_otp[i][m_idx[i][1:0]] = m_data[i];
            else if (m_idx[i] == 5'd9 && IRQ_EN) m_mask[i] = m_data[i][3:0];
          end else if (m_idx[i] == 5'd8) begin
            m_flags[i] = 4'd0;
          end
        end else if (!m_busy[i] && req[i] && addr[i][7]) begin
          m_busy[i]   = 1'b1;
          m_ack_at[i] = cyc + wait_of(i);
          m_we[i]     = we[i];
          m_idx[i]    = addr[i][6:2];
          m_data[i]   = datain[i];
        end
        m_flags[i] = m_flags[i] | set;
        m_irq[i]   = IRQ_EN ? |(m_flags[i] & m_mask[i]) : 1'b0;
        for (int n = 0; n < 4; n++) begin
          h3[i][n] = h2[i][n];
          h2[i][n] = h1[i][n];
          h1[i][n] = inp[i][n];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin : compare
    logic ea;
    if (resetn) begin
      for (int i = 0; i < 2; i++) begin
        ea = m_busy[i] && (m_ack_at[i] == cyc);
        chk("ack", i, 32'(ack_v[i]), 32'(ea));
        chk("dataout", i, dout_v[i], (ea && !m_we[i]) ? m_read(i) : 32'd0);
        for (int n = 0; n < 4; n++) chk("otp", i, otp_v[i][n], m_otp[i][n]);
        chk("irq", i, 32'(irq_v[i]), 32'(m_irq[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input int i, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int bound,
                     output logic [31:0] rd, output int lat);
    @(posedge clock); #1;
    req[i] = 1'b1; we[i] = w; addr[i] = a; datain[i] = d;
    lat = -1; rd = 32'd0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clock);
      if (ack_v[i]) begin
        lat = k; rd = dout_v[i];
        break;
      end
    end
    @(posedge clock); #1;
    req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; datain[i] = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd;
    int          lat;
    int          acks;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; datain[i] = 32'd0;
      for (int n = 0; n < 4; n++) inp[i][n] = 32'd0;
    end
    idle(3);
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_ack", 0, 32'(ack_v[0]), 32'd0);
    chk("rst_otp0", 1, otp_v[1][0], 32'd0);

    // WAIT_CYCLES = 0
    txn(0, 1'b1, 32'h84, 32'h12345678, 10, rd, lat);
    chk("st_lat", 0, 32'(lat), 32'd1);
    @(negedge clock);
    chk("st_otp1", 0, otp_v[0][1], 32'h12345678);
    txn(0, 1'b0, 32'h84, 32'd0, 10, rd, lat);
    chk("ld_lat", 0, 32'(lat), 32'd1);
    chk("ld_otp1", 0, rd, 32'h12345678);
    txn(0, 1'b1, 32'h90, 32'hDEADBEEF, 10, rd, lat);
    chk("ro_wr_lat", 0, 32'(lat), 32'd1);
    txn(0, 1'b0, 32'h90, 32'd0, 10, rd, lat);
    chk("ld_inp0", 0, rd, 32'd0);
    txn(0, 1'b1, 32'hB0, 32'hFFFFFFFF, 10, rd, lat);
    txn(0, 1'b0, 32'hB0, 32'd0, 10, rd, lat);
    chk("ld_unmapped", 0, rd, 32'd0);

    // WAIT_CYCLES = 3
    inp[1][0] = 32'hA5A5A5A5;
    idle(5);
    txn(1, 1'b0, 32'h90, 32'd0, 20, rd, lat);
    chk("w3_lat", 1, 32'(lat), 32'd4);
    chk("w3_inp0", 1, rd, 32'hA5A5A5A5);
    txn(1, 1'b0, 32'h10, 32'd0, 20, rd, lat);
    chk("low_addr_noack", 1, 32'(lat), 32'hFFFFFFFF);
    txn(1, 1'b1, 32'h8C, 32'hCAFEF00D, 20, rd, lat);
    txn(1, 1'b0, 32'h8C, 32'd0, 20, rd, lat);
    chk("w3_otp3", 1, rd, 32'hCAFEF00D);

    // change flags, read-clear
    inp[0][2] = 32'h1;
    idle(5);
    txn(0, 1'b0, 32'hA0, 32'd0, 10, rd, lat);
    chk("stat_set", 0, rd, 32'h4);
    txn(0, 1'b0, 32'hA0, 32'd0, 10, rd, lat);
    chk("stat_clr", 0, rd, 32'h0);
    inp[0][2] = 32'h0;
    idle(5);
    inp[0][2] = 32'h1;  // lands on the flag register at the same edge as the clear
    txn(0, 1'b0, 32'hA0, 32'd0, 10, rd, lat);
    chk("stat_a", 0, rd, 32'h4);
    txn(0, 1'b0, 32'hA0, 32'd0, 10, rd, lat);
    chk("stat_setwins", 0, rd, 32'h4);
    txn(0, 1'b0, 32'hA0, 32'd0, 10, rd, lat);
    chk("stat_c", 0, rd, 32'h0);

    // irq mask
    txn(0, 1'b1, 32'hA4, 32'h1, 10, rd, lat);
    txn(0, 1'b0, 32'hA4, 32'd0, 10, rd, lat);
    chk("mask_rd", 0, rd, IRQ_EN ? 32'h1 : 32'h0);
    inp[0][1] = 32'h10;
    idle(5);
    @(negedge clock);
    chk("irq_masked", 0, 32'(irq_v[0]), 32'd0);
    idle(1);
    inp[0][0] = 32'h1;
    idle(5);
    @(negedge clock);
    chk("irq_set", 0, 32'(irq_v[0]), IRQ_EN ? 32'd1 : 32'd0);
    txn(0, 1'b0, 32'hA0, 32'd0, 10, rd, lat);
    chk("irq_stat", 0, rd, 32'h3);
    @(negedge clock);
    chk("irq_drop", 0, 32'(irq_v[0]), 32'd0);

    // reset during wait states of a store
    idle(1);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h80; datain[1] = 32'h55AA55AA;
    repeat (2) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_ack", 1, 32'(ack_v[1]), 32'd0);
    chk("mid_rst_otp0", 1, otp_v[1][0], 32'd0);
    chk("mid_rst_otp3", 1, otp_v[1][3], 32'd0);
    chk("dirty_rst_otp1", 0, otp_v[0][1], 32'd0);
    chk("dirty_rst_dout", 0, dout_v[0], 32'd0);
    chk("dirty_rst_irq", 0, 32'(irq_v[0]), 32'd0);
    req[1] = 1'b0; we[1] = 1'b0; addr[1] = 32'd0; datain[1] = 32'd0;
    idle(2);
    resetn = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clock);
      if (ack_v[1]) acks++;
    end
    chk("post_rst_noack", 1, 32'(acks), 32'd0);
    chk("post_rst_otp0", 1, otp_v[1][0], 32'd0);
    // inputs held nonzero through reset show up as changes from the reset value
    txn(0, 1'b0, 32'hA0, 32'd0, 10, rd, lat);
    chk("post_rst_stat", 0, rd, 32'h7);

    idle(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
